// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath: FSM encoding, default word
// length and the count-width helper.
package serial_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first word assembler: load_first starts a new word at bit 0, shift
// places the next bit at the current count; done flags the final bit.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             load_first,
  input  logic             shift,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] data;
  logic [CW-1:0]    cnt;

  // Word as it would look with bit_in merged in; captured by the top on done.
  always_comb begin
    word      = data;
    word[cnt] = bit_in;
  end

  assign done = shift && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      cnt  <= '0;
    end else if (load_first) begin
      data <= {{(WIDTH-1){1'b0}}, bit_in};
      cnt  <= CW'(1);
    end else if (shift) begin
      data <= word;
      cnt  <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the serial sum stream into WIDTH-bit words, holds one word for a
// valid/ready consumer and records overrun/framing faults in sticky flags.
//
//   state   | meaning
//   IDLE    | waiting for bit_valid & sof
//   COLLECT | word in progress, bits 1..WIDTH-1 pending
module serial_sum_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clear_err
);

  state_t           state, state_next;
  logic             load_first, shift, done;
  logic             frame_set, overrun_set;
  logic [WIDTH-1:0] word_asm;

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .load_first (load_first),
    .shift      (shift),
    .word       (word_asm),
    .done       (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bit_valid && sof) state_next = COLLECT;
      COLLECT: if (done)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_first = 1'b0;
    shift      = 1'b0;
    frame_set  = 1'b0;
    busy       = (state == COLLECT);
    case (state)
      IDLE: load_first = bit_valid && sof;
      COLLECT: begin
        if (bit_valid && sof) begin
          load_first = 1'b1;
          frame_set  = 1'b1;
        end else if (bit_valid) begin
          shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A completing word may replace the held one only if it is consumed this cycle.
  assign overrun_set = done && word_valid && !word_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (done) begin
      if (!word_valid || word_ready) begin
        word_out   <= word_asm;
        word_valid <= 1'b1;
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set | (overrun & ~clear_err);
      frame_err <= frame_set | (frame_err & ~clear_err);
    end
  end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Self-checking bench for serial_sum_collector (WIDTH=8 plus a WIDTH=2 copy).
module tb_serial_sum_collector;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset, bit_in, bit_valid, sof, word_ready, clear_err;
  logic [W-1:0] word_out;
  logic word_valid, busy, overrun, frame_err;
  logic [1:0] word_out2;
  logic word_valid2, busy2, overrun2, frame_err2;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_sum_collector #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err)
  );

  serial_sum_collector #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .word_out(word_out2), .word_valid(word_valid2), .word_ready(word_ready),
    .busy(busy2), .overrun(overrun2), .frame_err(frame_err2), .clear_err(clear_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input logic s);
    bit_in = b; bit_valid = 1'b1; sof = s;
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input logic ready_last,
                           output int busy_low);
    busy_low = 0;
    for (int i = 0; i < W; i++) begin
      if (i == W-1 && ready_last) word_ready = 1'b1;
      drive_bit(w[i], i == 0);
      if (i == W-1 && ready_last) word_ready = 1'b0;
      if (i < W-1) begin
        if (!busy) busy_low++;
        for (int g = 0; g < gap; g++) begin
          step();
          if (!busy) busy_low++;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({word_valid, busy, overrun, frame_err, word_out} !== '0) begin
      n_err++; $display("FAIL reset_state got %b required 0", {word_valid, busy, overrun, frame_err, word_out});
    end
    n_cmp++;
    if ({word_valid2, busy2, overrun2, frame_err2, word_out2} !== '0) begin
      n_err++; $display("FAIL reset_state_w2 got %b required 0", {word_valid2, busy2, overrun2, frame_err2, word_out2});
    end
  endtask

  task automatic test_width2();
    word_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    n_cmp++;
    if (busy2 !== 1'b1 || word_valid2 !== 1'b0) begin
      n_err++; $display("FAIL w2_mid busy=%b valid=%b required busy=1 valid=0", busy2, word_valid2);
    end
    drive_bit(1'b0, 1'b0);
    n_cmp++;
    if (word_valid2 !== 1'b1 || word_out2 !== 2'b01 || busy2 !== 1'b0) begin
      n_err++; $display("FAIL w2_word valid=%b word=%b busy=%b required 1/01/0", word_valid2, word_out2, busy2);
    end
  endtask

  task automatic test_basic();
    int bl;
    logic [W-1:0] e;
    word_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 0, 1'b0, bl);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== e) begin
      n_err++; $display("FAIL basic_word valid=%b word=%h required 1/%h", word_valid, word_out, e);
    end
    n_cmp++;
    if ({overrun, frame_err} !== 2'b00 || bl != 0) begin
      n_err++; $display("FAIL basic_flags flags=%b busy_low=%0d required 00/0", {overrun, frame_err}, bl);
    end
    step();
    n_cmp++;
    if (word_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_valid_1cyc got %b required 0", word_valid);
    end
  endtask

  task automatic test_gaps();
    int bl, t;
    logic [W-1:0] e;
    word_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 3, 1'b0, bl);
    n_cmp++;
    if (bl != 0) begin
      n_err++; $display("FAIL gaps_busy low_cycles=%0d required 0", bl);
    end
    t = 0;
    while (!word_valid && t < 10) begin step(); t++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== e) begin
      n_err++; $display("FAIL gaps_word valid=%b word=%h required 1/%h", word_valid, word_out, e);
    end
    n_cmp++;
    if ({overrun, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL gaps_flags got %b required 00", {overrun, frame_err});
    end
    step();
  endtask

  task automatic test_overrun();
    int bl;
    logic [W-1:0] e;
    word_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 0, 1'b0, bl);
    send_word(8'hFF, 0, 1'b0, bl);
    n_cmp++;
    if (overrun !== 1'b1 || word_valid !== 1'b1) begin
      n_err++; $display("FAIL ovr_set overrun=%b valid=%b required 1/1", overrun, word_valid);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_clear got %b required 0", overrun);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_out !== e) begin
      n_err++; $display("FAIL ovr_held got %h required %h", word_out, e);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    n_cmp++;
    if (word_valid !== 1'b0) begin
      n_err++; $display("FAIL ovr_drain got %b required 0", word_valid);
    end
  endtask

  task automatic test_accept_replace();
    int bl;
    logic [W-1:0] e;
    word_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 0, 1'b0, bl);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== e) begin
      n_err++; $display("FAIL ar_first valid=%b word=%h required 1/%h", word_valid, word_out, e);
    end
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 0, 1'b1, bl);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== e || overrun !== 1'b0) begin
      n_err++; $display("FAIL ar_replace valid=%b word=%h overrun=%b required 1/%h/0", word_valid, word_out, overrun, e);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    n_cmp++;
    if (word_valid !== 1'b0) begin
      n_err++; $display("FAIL ar_drain got %b required 0", word_valid);
    end
  endtask

  task automatic test_frame();
    int bl;
    logic [W-1:0] e;
    word_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    n_cmp++;
    if (word_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL frame_partial valid=%b ferr=%b busy=%b required 0/0/1", word_valid, frame_err, busy);
    end
    exp_q.push_back(8'h81);
    send_word(8'h81, 0, 1'b0, bl);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (frame_err !== 1'b1 || word_valid !== 1'b1 || word_out !== e) begin
      n_err++; $display("FAIL frame_word ferr=%b valid=%b word=%h required 1/1/%h", frame_err, word_valid, word_out, e);
    end
    step();
    n_cmp++;
    if (word_valid !== 1'b0) begin
      n_err++; $display("FAIL frame_no_partial got %b required 0", word_valid);
    end
    drive_bit(1'b0, 1'b1);
    clear_err = 1'b1;
    drive_bit(1'b0, 1'b1);
    clear_err = 1'b0;
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_err++; $display("FAIL frame_set_wins got %b required 1", frame_err);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_cmp++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL frame_clear ferr=%b busy=%b required 0/1", frame_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    int bl;
    logic [W-1:0] e;
    word_ready = 1'b0;
    send_word(8'h11, 0, 1'b0, bl);
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    n_cmp++;
    if (word_valid !== 1'b1 || busy !== 1'b1 || word_out !== 8'h11 || frame_err !== 1'b1) begin
      n_err++; $display("FAIL rst_pre valid=%b busy=%b word=%h ferr=%b required 1/1/11/1", word_valid, busy, word_out, frame_err);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({word_valid, busy, overrun, frame_err, word_out} !== '0) begin
      n_err++; $display("FAIL rst_async got %b required 0", {word_valid, busy, overrun, frame_err, word_out});
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    n_cmp++;
    if (busy !== 1'b0 || word_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_nosof busy=%b valid=%b required 0/0", busy, word_valid);
    end
    word_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1, 1'b0, bl);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== e || {overrun, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL rst_after valid=%b word=%h flags=%b required 1/%h/00", word_valid, word_out, {overrun, frame_err}, e);
    end
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_left got %0d entries required 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    word_ready = 1'b0; clear_err = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    test_reset();
    test_width2();
    pulse_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_accept_replace();
    test_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
